conv_layer_sched: RTL and testbench

- Channel-level scheduler for the layer-1 convolution input controller.
- On a start pulse it runs one full input-window pass per output channel, num_ch_i passes in total, using that controller's ConvValid/vbit handshake.
- For each pass it drives the weight-bank index, then raises completion status and an interrupt to the Cortex-M3 subsystem.
- Sits between the CPU-facing accelerator register block and the L1 conv input controller.

---
 rtl/conv_layer_sched.sv | 170 +++++++++++++++++
 tb/tb_conv_layer_sched.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_layer_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | conv_layer_sched: per-channel ConvValid/vbit pass scheduler for L1 conv   |
// | Optional watchdog: CONV_SCHED_WDOG_EN.  Revision: 1.0                     |
// +--------------------------------------------------------------------------+
module conv_layer_sched #(
  parameter int CH_W    = 6,
  parameter int GAP_CYC = 2,
  parameter int WDOG_W  = 12
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start_i,
  input  logic [CH_W-1:0] num_ch_i,
  input  logic            abort_i,
  input  logic            vbit_i,
  output logic            conv_valid_o,
  output logic [CH_W-1:0] ch_idx_o,
  output logic            ch_done_o,
  output logic            busy_o,
  output logic            done_irq_o,
  input  logic            irq_clr_i,
  output logic            err_o
);

  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_RUN    = 3'd2,
    S_DRAIN  = 3'd3,
    S_GAP    = 3'd4,
    S_FINISH = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   num_ch_q, num_ch_d;
  logic [CH_W-1:0]   ch_idx_q, ch_idx_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              conv_valid_q, conv_valid_d;
  logic              ch_done_q, ch_done_d;
  logic              busy_q, busy_d;
  logic              done_irq_q, done_irq_d;
  logic              abort_hit;
  logic              wdog_trip;
  logic              irq_set;

`ifdef CONV_SCHED_WDOG_EN
  logic [WDOG_W-1:0] wdog_q, wdog_d, wdog_inc;
  logic              err_q, err_d;
`endif

  always_comb begin
    state_d   = state_q;
    num_ch_d  = num_ch_q;
    ch_idx_d  = ch_idx_q;
    gap_d     = gap_q;
    wdog_trip = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          num_ch_d = num_ch_i;
          if (num_ch_i != '0) begin
            ch_idx_d = '0;
            state_d  = S_LAUNCH;
          end else begin
            state_d  = S_FINISH;
          end
        end
      end
      S_LAUNCH: if (vbit_i)  state_d = S_RUN;
      S_RUN:    if (!vbit_i) state_d = S_DRAIN;
      S_DRAIN: begin
        if (ch_idx_q == num_ch_q - CH_W'(1)) begin
          state_d = S_FINISH;
        end else begin
          ch_idx_d = ch_idx_q + CH_W'(1);
          gap_d    = GAP_W'(GAP_CYC - 1);
          state_d  = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q == '0) state_d = S_LAUNCH;
        else             gap_d   = gap_q - GAP_W'(1);
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

`ifdef CONV_SCHED_WDOG_EN
    wdog_inc  = wdog_q + WDOG_W'(1);
    wdog_trip = ((state_q == S_LAUNCH) || (state_q == S_RUN)) &&
                (state_d == state_q) && (&wdog_inc);
    if (wdog_trip) state_d = S_IDLE;
`endif

    // Abort overrides every other transition and leaves the channel index alone.
    abort_hit = abort_i && (state_q != S_IDLE);
    if (abort_hit) begin
      state_d  = S_IDLE;
      ch_idx_d = ch_idx_q;
      gap_d    = gap_q;
    end

    // Setting while FINISH is current keeps an irq_clr in that cycle from winning.
    irq_set = !abort_hit &&
              ((state_d == S_FINISH) || (state_q == S_FINISH) || wdog_trip);
    if (irq_set)        done_irq_d = 1'b1;
    else if (irq_clr_i) done_irq_d = 1'b0;
    else                done_irq_d = done_irq_q;

    conv_valid_d = (state_d == S_LAUNCH) || (state_d == S_RUN);
    ch_done_d    = (state_d == S_DRAIN);
    busy_d       = (state_d != S_IDLE);

`ifdef CONV_SCHED_WDOG_EN
    wdog_d = (((state_d == S_LAUNCH) || (state_d == S_RUN)) && (state_d == state_q))
             ? wdog_inc : '0;
    if (wdog_trip && !abort_hit) err_d = 1'b1;
    else if (irq_clr_i)          err_d = 1'b0;
    else                         err_d = err_q;
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      num_ch_q     <= '0;
      ch_idx_q     <= '0;
      gap_q        <= '0;
      conv_valid_q <= 1'b0;
      ch_done_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_irq_q   <= 1'b0;
`ifdef CONV_SCHED_WDOG_EN
      wdog_q       <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      num_ch_q     <= num_ch_d;
      ch_idx_q     <= ch_idx_d;
      gap_q        <= gap_d;
      conv_valid_q <= conv_valid_d;
      ch_done_q    <= ch_done_d;
      busy_q       <= busy_d;
      done_irq_q   <= done_irq_d;
`ifdef CONV_SCHED_WDOG_EN
      wdog_q       <= wdog_d;
      err_q        <= err_d;
`endif
    end
  end

  assign conv_valid_o = conv_valid_q;
  assign ch_idx_o     = ch_idx_q;
  assign ch_done_o    = ch_done_q;
  assign busy_o       = busy_q;
  assign done_irq_o   = done_irq_q;

`ifdef CONV_SCHED_WDOG_EN
  assign err_o = err_q;
`else
  // WDOG_W only sizes the watchdog; referenced here so both builds share one parameter list.
  assign err_o = 1'b0 & (WDOG_W > 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_conv_layer_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_conv_layer_sched: directed bench for conv_layer_sched                  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_conv_layer_sched;

`ifdef CONV_SCHED_WDOG_EN
  localparam int TB_WDOG_W = 4;
`else
  localparam int TB_WDOG_W = 12;
`endif

  logic       clk = 1'b0;
  logic       rstn;
  logic       start_i;
  logic [5:0] num_ch_i;
  logic       abort_i;
  logic       vbit_i;
  logic       conv_valid_o;
  logic [5:0] ch_idx_o;
  logic       ch_done_o;
  logic       busy_o;
  logic       done_irq_o;
  logic       irq_clr_i;
  logic       err_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  conv_layer_sched #(.CH_W(6), .GAP_CYC(2), .WDOG_W(TB_WDOG_W)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .start_i      (start_i),
    .num_ch_i     (num_ch_i),
    .abort_i      (abort_i),
    .vbit_i       (vbit_i),
    .conv_valid_o (conv_valid_o),
    .ch_idx_o     (ch_idx_o),
    .ch_done_o    (ch_done_o),
    .busy_o       (busy_o),
    .done_irq_o   (done_irq_o),
    .irq_clr_i    (irq_clr_i),
    .err_o        (err_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered with conv_valid just risen; ends in the DRAIN cycle.
  task automatic run_pass(input logic [5:0] idx);
    tick();
    tick();
    check("launch_cv", conv_valid_o, 1);
    check("launch_busy", busy_o, 1);
    vbit_i = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("run_cv", conv_valid_o, 1);
    check("run_done", ch_done_o, 0);
    vbit_i = 1'b0;
    tick();
    check("drain_cv", conv_valid_o, 0);
    check("drain_done", ch_done_o, 1);
    check("drain_idx", ch_idx_o, idx);
  endtask

  // From DRAIN: three low cycles, then conv_valid rises with the new index.
  task automatic gap_check(input logic [5:0] next_idx);
    tick();
    check("gap1_cv", conv_valid_o, 0);
    check("gap1_done", ch_done_o, 0);
    check("gap1_idx", ch_idx_o, next_idx);
    tick();
    check("gap2_cv", conv_valid_o, 0);
    tick();
    check("relaunch_cv", conv_valid_o, 1);
    check("relaunch_idx", ch_idx_o, next_idx);
  endtask

  initial begin
    rstn      = 1'b0;
    start_i   = 1'b0;
    num_ch_i  = '0;
    abort_i   = 1'b0;
    vbit_i    = 1'b0;
    irq_clr_i = 1'b0;
    #3;
    check("rst_cv", conv_valid_o, 0);
    check("rst_idx", ch_idx_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_irq", done_irq_o, 0);
    check("rst_done", ch_done_o, 0);
    check("rst_err", err_o, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    tick();

    // Normal 3-channel run, with a start request ignored while busy.
    start_i = 1'b1; num_ch_i = 6'd3;
    tick();
    start_i = 1'b0;
    check("n_start_cv", conv_valid_o, 1);
    check("n_start_busy", busy_o, 1);
    check("n_start_idx", ch_idx_o, 0);
    run_pass(6'd0);
    start_i = 1'b1; num_ch_i = 6'd5;
    gap_check(6'd1);
    start_i = 1'b0;
    run_pass(6'd1);
    gap_check(6'd2);
    run_pass(6'd2);
    irq_clr_i = 1'b1;
    tick();
    check("fin_irq", done_irq_o, 1);
    check("fin_busy", busy_o, 1);
    check("fin_cv", conv_valid_o, 0);
    tick();
    irq_clr_i = 1'b0;
    check("race_irq", done_irq_o, 1);
    check("idle_busy", busy_o, 0);
    check("idle_idx", ch_idx_o, 2);
    tick();
    check("sticky_irq", done_irq_o, 1);
    irq_clr_i = 1'b1;
    tick();
    irq_clr_i = 1'b0;
    check("clr_irq", done_irq_o, 0);

    // Zero channel count.
    start_i = 1'b1; num_ch_i = 6'd0;
    tick();
    start_i = 1'b0;
    check("z_cv1", conv_valid_o, 0);
    check("z_busy1", busy_o, 1);
    tick();
    check("z_irq", done_irq_o, 1);
    check("z_busy2", busy_o, 0);
    check("z_cv2", conv_valid_o, 0);
    check("z_done", ch_done_o, 0);
    irq_clr_i = 1'b1;
    tick();
    irq_clr_i = 1'b0;
    check("z_clr", done_irq_o, 0);

    // Abort in RUN of channel 1 of 4.
    start_i = 1'b1; num_ch_i = 6'd4;
    tick();
    start_i = 1'b0;
    run_pass(6'd0);
    gap_check(6'd1);
    tick();
    tick();
    vbit_i = 1'b1;
    tick();
    tick();
    check("a_run_cv", conv_valid_o, 1);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    vbit_i  = 1'b0;
    check("a_cv", conv_valid_o, 0);
    check("a_busy", busy_o, 0);
    check("a_irq", done_irq_o, 0);
    check("a_idx", ch_idx_o, 1);
    tick();
    check("a_idle_cv", conv_valid_o, 0);
    check("a_idle_irq", done_irq_o, 0);

    // Asynchronous reset mid-GAP, then a fresh 2-channel run.
    start_i = 1'b1; num_ch_i = 6'd3;
    tick();
    start_i = 1'b0;
    run_pass(6'd0);
    tick();
    check("r_gap_idx", ch_idx_o, 1);
    #2 rstn = 1'b0;
    #1;
    check("r_cv", conv_valid_o, 0);
    check("r_idx", ch_idx_o, 0);
    check("r_busy", busy_o, 0);
    check("r_irq", done_irq_o, 0);
    check("r_done", ch_done_o, 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    tick();
    start_i = 1'b1; num_ch_i = 6'd2;
    tick();
    start_i = 1'b0;
    check("r2_cv", conv_valid_o, 1);
    check("r2_idx", ch_idx_o, 0);
    run_pass(6'd0);
    gap_check(6'd1);
    run_pass(6'd1);
    tick();
    check("r2_fin_irq", done_irq_o, 1);
    check("r2_fin_busy", busy_o, 1);
    tick();
    check("r2_idle_busy", busy_o, 0);
    check("r2_idle_idx", ch_idx_o, 1);
    irq_clr_i = 1'b1;
    tick();
    irq_clr_i = 1'b0;

`ifdef CONV_SCHED_WDOG_EN
    // Stuck vbit: 15 LAUNCH cycles, then the watchdog forces IDLE.
    start_i = 1'b1; num_ch_i = 6'd1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      check("w_cv", conv_valid_o, 1);
    end
    check("w_err_pre", err_o, 0);
    tick();
    check("w_err", err_o, 1);
    check("w_irq", done_irq_o, 1);
    check("w_cv_off", conv_valid_o, 0);
    check("w_busy", busy_o, 0);
    irq_clr_i = 1'b1;
    tick();
    irq_clr_i = 1'b0;
    check("w_err_clr", err_o, 0);
`else
    check("no_wdog_err", err_o, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
